// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch in packed BCD, paced by rising edges of the divider's square wave.
// A small FSM (IDLE/RUN/PAUSED/OVF) is sequenced by start/stop presses and a level clear.
module bcd_stopwatch #(
   parameter int TICKS_PER_SEC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_in,
   input  logic        start_stop,
   input  logic        clear,
   output logic [15:0] time_bcd,
   output logic        running,
   output logic        ovf,
   output logic        sec_pulse
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      OVF    = 2'd3
   } state_t;

   localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);

   state_t      state;
   logic [7:0]  presc;
   logic        tick_q;
   logic        ss_q;
   logic        tick_rise;
   logic        ss_rise;
   logic [16:0] inc_res;

   // One-second BCD increment; bit 16 flags a carry out of 99:59.
   function automatic logic [16:0] bcd_inc(input logic [15:0] t);
      logic [3:0] su, st, mu, mt;
      logic       c;
      {mt, mu, st, su} = t;
      c = 1'b0;
      if (su == 4'd9) begin
         su = 4'd0;
         if (st == 4'd5) begin
            st = 4'd0;
            if (mu == 4'd9) begin
               mu = 4'd0;
               if (mt == 4'd9) c = 1'b1;
               else            mt = mt + 4'd1;
            end else begin
               mu = mu + 4'd1;
            end
         end else begin
            st = st + 4'd1;
         end
      end else begin
         su = su + 4'd1;
      end
      return {c, mt, mu, st, su};
   endfunction

   assign tick_rise = tick_in & ~tick_q;
   assign ss_rise   = start_stop & ~ss_q;
   assign inc_res   = bcd_inc(time_bcd);

   // Edge-detect history; reset high so a level already high at release is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_q <= 1'b1;
         ss_q   <= 1'b1;
      end else begin
         tick_q <= tick_in;
         ss_q   <= start_stop;
      end
   end

   // Stopwatch FSM with prescaler, BCD time and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         time_bcd  <= 16'h0000;
         presc     <= 8'd0;
         running   <= 1'b0;
         ovf       <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         sec_pulse <= 1'b0;
         if (clear) begin
            state    <= IDLE;
            time_bcd <= 16'h0000;
            presc    <= 8'd0;
            running  <= 1'b0;
            ovf      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_rise) begin
                     state   <= RUN;
                     presc   <= 8'd0;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  // Overflow wins over a same-cycle press: the count is over.
                  if (tick_rise && presc == PRESC_MAX && inc_res[16]) begin
                     presc   <= 8'd0;
                     state   <= OVF;
                     running <= 1'b0;
                     ovf     <= 1'b1;
                  end else begin
                     if (tick_rise) begin
                        if (presc == PRESC_MAX) begin
                           presc     <= 8'd0;
                           time_bcd  <= inc_res[15:0];
                           sec_pulse <= 1'b1;
                        end else begin
                           presc <= presc + 8'd1;
                        end
                     end
                     if (ss_rise) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                     end
                  end
               end
               PAUSED: begin
                  if (ss_rise) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               OVF: begin
                  state <= OVF;
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
                  ovf     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: directed scenarios plus random stimulus against a
// model that counts elapsed seconds as an integer and formats MM:SS from it.
module tb_bcd_stopwatch;

   localparam int TPS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick_in;
   logic        start_stop;
   logic        clear;
   logic [15:0] time_bcd;
   logic        running;
   logic        ovf;
   logic        sec_pulse;

   int n_vec = 0;
   int n_err = 0;

   // model state: 0 idle, 1 run, 2 paused, 3 overflow
   int m_state;
   int m_secs;
   int m_presc;
   bit m_tq, m_sq, m_pulse;
   bit cur_tick, cur_ss;
   int pulse_cnt;

   bcd_stopwatch #(.TICKS_PER_SEC(TPS)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .clear      (clear),
      .time_bcd   (time_bcd),
      .running    (running),
      .ovf        (ovf),
      .sec_pulse  (sec_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_secs = 0; m_presc = 0;
      m_tq = 1'b1; m_sq = 1'b1; m_pulse = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit c);
      bit tr, sr;
      tr = t & ~m_tq;
      sr = s & ~m_sq;
      m_tq = t;
      m_sq = s;
      m_pulse = 1'b0;
      if (c) begin
         m_state = 0; m_secs = 0; m_presc = 0;
      end else begin
         case (m_state)
            0: if (sr) begin m_state = 1; m_presc = 0; end
            1: begin
               if (tr) begin
                  if (m_presc == TPS - 1) begin
                     m_presc = 0;
                     if (m_secs == 99 * 60 + 59) m_state = 3;
                     else begin m_secs++; m_pulse = 1'b1; end
                  end else begin
                     m_presc++;
                  end
               end
               if (sr && m_state == 1) m_state = 2;
            end
            2: if (sr) m_state = 1;
            default: ;
         endcase
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".time"}, 32'(time_bcd), 32'(to_bcd(m_secs)));
      check({tag, ".running"}, 32'(running), 32'(m_state == 1));
      check({tag, ".ovf"}, 32'(ovf), 32'(m_state == 3));
      check({tag, ".pulse"}, 32'(sec_pulse), 32'(m_pulse));
   endtask

   // Drive one cycle from a negedge, advance the model, sample at the next negedge.
   task automatic step(input bit t, input bit s, input bit c);
      tick_in = t; start_stop = s; clear = c;
      cur_tick = t; cur_ss = s;
      model_step(t, s, c);
      @(negedge clk);
      if (sec_pulse) pulse_cnt++;
      compare_all("step");
   endtask

   task automatic do_tick();
      step(1'b0, cur_ss, 1'b0);
      step(1'b1, cur_ss, 1'b0);
   endtask

   task automatic do_press();
      step(cur_tick, 1'b0, 1'b0);
      step(cur_tick, 1'b1, 1'b0);
   endtask

   task automatic do_clear();
      step(cur_tick, cur_ss, 1'b1);
      step(cur_tick, cur_ss, 1'b0);
   endtask

   task automatic run_to(input int target);
      for (int g = 0; g < 30000 && m_secs < target; g++) do_tick();
      check("run_to.reached", 32'(m_secs), 32'(target));
   endtask

   initial begin
      model_reset();
      reset = 1'b1; tick_in = 1'b1; start_stop = 1'b1; clear = 1'b0;
      cur_tick = 1'b1; cur_ss = 1'b1; pulse_cnt = 0;
      repeat (3) @(negedge clk);
      check("rst.time", 32'(time_bcd), 32'h0);
      check("rst.running", 32'(running), 32'h0);
      check("rst.ovf", 32'(ovf), 32'h0);
      check("rst.pulse", 32'(sec_pulse), 32'h0);
      reset = 1'b0;

      // inputs high across reset release are not edges
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("hold.running", 32'(running), 32'h0);
      do_press();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("hold.time", 32'(time_bcd), 32'h0000);
      check("hold.run", 32'(running), 32'h1);

      // four ticks from a fresh start give two seconds
      do_clear();
      do_press();
      pulse_cnt = 0;
      repeat (4) do_tick();
      check("four.time", 32'(time_bcd), 32'h0002);
      check("four.pulses", 32'(pulse_cnt), 32'd2);
      check("four.running", 32'(running), 32'h1);

      // digit carries
      run_to(59);
      repeat (2) do_tick();
      check("carry.0100", 32'(time_bcd), 32'h0100);
      run_to(9 * 60 + 59);
      repeat (2) do_tick();
      check("carry.1000", 32'(time_bcd), 32'h1000);

      // overflow and its hold behaviour
      run_to(99 * 60 + 58);
      repeat (4) do_tick();
      check("ovf.time", 32'(time_bcd), 32'h9959);
      check("ovf.flag", 32'(ovf), 32'h1);
      check("ovf.running", 32'(running), 32'h0);
      repeat (3) begin do_tick(); do_press(); end
      check("ovf.hold", 32'(time_bcd), 32'h9959);
      check("ovf.stay", 32'(ovf), 32'h1);
      do_clear();
      check("ovf.clr.time", 32'(time_bcd), 32'h0000);
      check("ovf.clr.flag", 32'(ovf), 32'h0);

      // pause keeps the prescaler
      do_press();
      do_tick();
      do_press();
      repeat (3) do_tick();
      check("pause.time", 32'(time_bcd), 32'h0000);
      do_press();
      do_tick();
      check("resume.time", 32'(time_bcd), 32'h0001);
      check("resume.pulse", 32'(sec_pulse), 32'h1);

      // clear beats a same-cycle tick
      do_clear();
      do_press();
      repeat (10) do_tick();
      check("pre5.time", 32'(time_bcd), 32'h0005);
      step(1'b0, cur_ss, 1'b0);
      step(1'b1, cur_ss, 1'b1);
      check("clrtick.time", 32'(time_bcd), 32'h0000);
      check("clrtick.running", 32'(running), 32'h0);
      step(1'b1, cur_ss, 1'b0);

      // press with the completing tick: tick counts, then pause
      do_press();
      repeat (11) do_tick();
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("sstick.time", 32'(time_bcd), 32'h0006);
      check("sstick.running", 32'(running), 32'h0);

      // asynchronous reset mid-count
      do_press();
      repeat (3) do_tick();
      #2 reset = 1'b1;
      #1;
      check("arst.time", 32'(time_bcd), 32'h0);
      check("arst.running", 32'(running), 32'h0);
      check("arst.pulse", 32'(sec_pulse), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         bit t, s, c;
         t = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 5) == 0) ? ~cur_ss : cur_ss;
         c = ($urandom_range(0, 99) == 0);
         step(t, s, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Consumes the slow square wave produced by the divider stage (its MSB output) and turns each rising edge into a time base for an MM:SS stopwatch in packed BCD.
- Start/stop button press and clear control a small FSM; outputs drive the display/mux stage downstream.
- Single clock domain; tick_in is a registered output of the divider, already synchronous to clk.

Parameters:
- TICKS_PER_SEC, 2, number of tick_in rising edges per one-second increment; legal 1..255; prescaler width 8 bits.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- tick_in  input  1  divider square wave (synchronous to clk)
- start_stop  input  1  level from the debounced button; a rising edge is one press
- clear  input  1  synchronous clear, level-sensitive, highest priority
- time_bcd  output  16  {min_tens, min_units, sec_tens, sec_units}, 4 bits each
- running  output  1  high in state RUN
- ovf  output  1  high in state OVF
- sec_pulse  output  1  one-cycle pulse on each seconds increment

Behaviour:
- Reset (async, active-high): state=IDLE, time_bcd=16'h0000, prescaler=0, running=0, ovf=0, sec_pulse=0. Edge registers tick_q=1 and ss_q=1, so an input already high at reset release is not an edge.
- Edge detect: tick_rise = tick_in & ~tick_q; ss_rise = start_stop & ~ss_q. Both are evaluated in the current cycle; tick_q and ss_q update every clock.
- FSM states: IDLE, RUN, PAUSED, OVF.
  - IDLE --ss_rise--> RUN; prescaler is 0 on entry.
  - RUN --ss_rise--> PAUSED.
  - PAUSED --ss_rise--> RUN; prescaler value is retained.
  - RUN --increment from 99:59--> OVF.
  - OVF ignores ss_rise and tick_in and holds time_bcd=16'h9959; only clear or reset leaves it.
  - clear=1 in any state --> IDLE next edge: time_bcd=0, prescaler=0, sec_pulse=0. Clear overrides ss_rise and tick_rise in the same cycle.
- Prescaler:
  - Only in RUN, on tick_rise: if prescaler==TICKS_PER_SEC-1, then prescaler<=0 and the time increments; else prescaler<=prescaler+1.
  - Frozen in PAUSED.
- Latency: time_bcd and sec_pulse update on the clock edge that ends the cycle in which tick_rise completes the prescaler. sec_pulse is registered, high for exactly that one cycle.
- BCD increment cascade:
  - sec_units 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_units.
  - min_units 9->0 carries into min_tens.
  - min_tens 9 with carry: go to OVF with time held at 99:59.
  - Each digit always stays within 0-9; sec_tens stays within 0-5.
- The OVF entry edge does not assert sec_pulse; it asserts ovf.
- Simultaneous ss_rise and tick_rise:
  - In RUN: the tick is processed (may increment), then the state goes to PAUSED.
  - In PAUSED: the tick is ignored, then the state goes to RUN.
  - In IDLE: the tick is ignored; the prescaler starts at 0.
- running and ovf are decoded from the registered state. They are glitch-free and valid the cycle after the transition edge.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock.

Test Plan:
- Reset with tick_in=1 held high, release, start pressed: no increment until tick_in falls and rises again; time_bcd stays 16'h0000.
- TICKS_PER_SEC=2, press start, apply 4 tick rising edges: time_bcd=16'h0002; sec_pulse is high for exactly 2 single cycles; running=1.
- Run to 00:59, then 2 more ticks: time_bcd=16'h0100. Run to 09:59 then 2 ticks: time_bcd=16'h1000.
- Preload by running to 99:58, 4 ticks: time_bcd=16'h9959, ovf=1, running=0. Further ticks and start presses change nothing; clear gives time_bcd=16'h0000, state IDLE.
- After 1 tick (prescaler=1), press start to pause, then 3 ticks, then resume and 1 tick: time_bcd=16'h0001 and sec_pulse fires on that resume tick.
- Same-cycle events:
  - clear and tick_rise in RUN at 00:05: result 16'h0000, IDLE.
  - ss_rise and the completing tick_rise in RUN at 00:05: result 16'h0006, PAUSED.
